pre_div_prog: RTL and testbench

- Programmable integer reference pre-divider for the PLL front end. Divides clk_in by a runtime-loadable ratio P and produces the reference clock clk_ref plus a one-cycle strobe at each clk_ref rising edge.
- Ratio changes are shadowed and applied only at period boundaries, so no runt pulses reach the phase detector.
- Fully synchronous to clk_in; clk_ref is a registered output, never gated.

---
 rtl/pll_pkg.sv | 20 ++
 rtl/pre_div_prog_if.sv | 32 +++
 rtl/pre_div_prog.sv | 97 +++++++++
 tb/tb_pre_div_prog.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pll_pkg.sv
// Shared types and helpers for the PLL front-end blocks.
//   PLL_DIV_W    : default width of divide ratios
//   div_t        : divide-ratio type at the default width
//   div_sanitize : maps a ratio of 0 to 1 (0 is not a meaningful divisor)
//   div_high     : high-phase length ceil(P/2), one bit wider than the ratio
package pll_pkg;

  localparam int PLL_DIV_W = 6;

  typedef logic [PLL_DIV_W-1:0] div_t;

  function automatic div_t div_sanitize(input div_t v);
    return (v == '0) ? div_t'(1) : v;
  endfunction

  function automatic logic [PLL_DIV_W:0] div_high(input div_t v);
    return ({1'b0, v} + (PLL_DIV_W+1)'(1)) >> 1;
  endfunction

endpackage

// File: rtl/pre_div_prog_if.sv
// Control/status bundle of the programmable reference pre-divider.
//   en        : count enable (low freezes division)
//   p         : requested divide ratio
//   p_load    : one-cycle request to capture p
//   clk_ref   : divided reference clock
//   ref_stb   : one-cycle strobe on each clk_ref rising edge
//   p_active  : ratio in effect (0 already mapped to 1)
//   p_pending : a loaded ratio waits for the next period boundary
// master drives the requests; slave is the divider itself.
interface pre_div_prog_if #(
  parameter int DIV_W = 6
) ();

  logic             en;
  logic [DIV_W-1:0] p;
  logic             p_load;
  logic             clk_ref;
  logic             ref_stb;
  logic [DIV_W-1:0] p_active;
  logic             p_pending;

  modport master (
    output en, p, p_load,
    input  clk_ref, ref_stb, p_active, p_pending
  );

  modport slave (
    input  en, p, p_load,
    output clk_ref, ref_stb, p_active, p_pending
  );

endinterface

// File: rtl/pre_div_prog.sv
// Programmable integer reference pre-divider.
// Divides clk_in by a runtime-loadable ratio P. clk_ref is high for
// ceil(P/2) cycles then low for the rest of the period; ref_stb pulses with
// every clk_ref rising edge. New ratios are held in a shadow register and
// applied only at a period boundary, so a running period is never cut short
// or stretched.
// Ports:
//   clk_in : system clock, all state on its rising edge
//   rst    : synchronous active-high reset
//   bus    : pre_div_prog_if.slave (en, p, p_load in; clk_ref, ref_stb,
//            p_active, p_pending out)
module pre_div_prog
  import pll_pkg::*;
#(
  parameter int DIV_W       = PLL_DIV_W,
  parameter int DEFAULT_DIV = 1
) (
  input  logic          clk_in,
  input  logic          rst,
  pre_div_prog_if.slave bus
);

  localparam logic [DIV_W-1:0] DEF_P = DIV_W'(DEFAULT_DIV);

  // Width-generic versions of the package helpers so DIV_W may differ
  // from the package default.
  function automatic logic [DIV_W-1:0] sanitize_p(input logic [DIV_W-1:0] v);
    return (v == '0) ? DIV_W'(1) : v;
  endfunction

  function automatic logic [DIV_W:0] high_len(input logic [DIV_W-1:0] v);
    return ({1'b0, v} + (DIV_W+1)'(1)) >> 1;
  endfunction

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] p_act;
  logic [DIV_W-1:0] shadow;
  logic             pending;
  logic             start;
  logic             clk_ref_r;
  logic             ref_stb_r;

  logic             boundary;
  logic [DIV_W:0]   cnt_inc;
  logic [DIV_W:0]   high;

  always_comb begin
    cnt_inc  = {1'b0, cnt} + (DIV_W+1)'(1);
    high     = high_len(p_act);
    // p_act is never 0, so p_act-1 cannot wrap.
    boundary = bus.en && (start || (cnt == p_act - DIV_W'(1)));
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt       <= '0;
      clk_ref_r <= 1'b0;
      ref_stb_r <= 1'b0;
      p_act     <= DEF_P;
      shadow    <= '0;
      pending   <= 1'b0;
      start     <= 1'b1;
    end else begin
      ref_stb_r <= 1'b0;
      if (boundary) begin
        cnt       <= '0;
        clk_ref_r <= 1'b1;
        ref_stb_r <= 1'b1;
        start     <= 1'b0;
        // A load in the boundary cycle itself takes effect immediately and
        // supersedes anything already waiting in the shadow.
        if (bus.p_load) begin
          p_act   <= sanitize_p(bus.p);
          pending <= 1'b0;
        end else if (pending) begin
          p_act   <= sanitize_p(shadow);
          pending <= 1'b0;
        end
      end else begin
        if (bus.en) begin
          cnt       <= cnt_inc[DIV_W-1:0];
          clk_ref_r <= (cnt_inc < high);
        end
        if (bus.p_load) begin
          shadow  <= bus.p;
          pending <= 1'b1;
        end
      end
    end
  end

  assign bus.clk_ref   = clk_ref_r;
  assign bus.ref_stb   = ref_stb_r;
  assign bus.p_active  = p_act;
  assign bus.p_pending = pending;

endmodule

// File: tb/tb_pre_div_prog.sv
module tb_pre_div_prog;

  localparam int DW  = 6;
  localparam int DEF = 1;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;

  pre_div_prog_if #(.DIV_W(DW)) bus ();

  pre_div_prog #(.DIV_W(DW), .DEFAULT_DIV(DEF)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic          clk_ref;
    logic          stb;
    logic [DW-1:0] pa;
    logic          pend;
    logic [31:0]   cyc;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: position within the current period and its length.
  int m_pos, m_per, m_shadow;
  bit m_first, m_pend, m_clk, m_stb;

  task automatic model_reset();
    m_pos = 0; m_per = DEF; m_shadow = 0;
    m_first = 1; m_pend = 0; m_clk = 0; m_stb = 0;
  endtask

  task automatic model_step(input bit r, input bit e, input bit pl, input int pv);
    bit bnd;
    if (r) begin
      model_reset();
    end else begin
      bnd   = 0;
      m_stb = 0;
      if (e) begin
        if (m_first || m_pos == m_per - 1) begin
          bnd = 1; m_first = 0; m_pos = 0; m_stb = 1;
          if (pl) begin
            m_per = (pv == 0) ? 1 : pv; m_pend = 0;
          end else if (m_pend) begin
            m_per = (m_shadow == 0) ? 1 : m_shadow; m_pend = 0;
          end
        end else begin
          m_pos++;
        end
        // high during the first ceil(per/2) positions of the period
        m_clk = (2 * m_pos < m_per);
      end
      if (pl && !bnd) begin
        m_shadow = pv; m_pend = 1;
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input bit pl, input int pv);
    exp_t x;
    @(negedge clk_in);
    rst        = r;
    bus.en     = e;
    bus.p_load = pl;
    bus.p      = DW'(pv);
    model_step(r, e, pl, pv);
    x.clk_ref = m_clk;
    x.stb     = m_stb;
    x.pa      = DW'(m_per);
    x.pend    = m_pend;
    x.cyc     = cyc;
    cyc++;
    sb.push_back(x);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0);
  endtask

  // Monitor: the divider presents a result every edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (bus.clk_ref !== e.clk_ref) begin
          errors++;
          $display("FAIL clk_ref cyc=%0d got=%b exp=%b", e.cyc, bus.clk_ref, e.clk_ref);
        end
        checks++;
        if (bus.ref_stb !== e.stb) begin
          errors++;
          $display("FAIL ref_stb cyc=%0d got=%b exp=%b", e.cyc, bus.ref_stb, e.stb);
        end
        checks++;
        if (bus.p_active !== e.pa) begin
          errors++;
          $display("FAIL p_active cyc=%0d got=%0d exp=%0d", e.cyc, bus.p_active, e.pa);
        end
        checks++;
        if (bus.p_pending !== e.pend) begin
          errors++;
          $display("FAIL p_pending cyc=%0d got=%b exp=%b", e.cyc, bus.p_pending, e.pend);
        end
      end
    end
  end

  initial begin : driver
    bus.en = 1'b0; bus.p = '0; bus.p_load = 1'b0;
    model_reset();

    // Reset, then continuous strobe at the default ratio of 1.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    run(6);

    // Ratio 4, then ratio 5.
    step(0, 1, 1, 4);
    run(13);
    step(0, 1, 1, 5);
    run(15);

    // Running at 6, load 3 mid-period at cnt=2.
    step(0, 1, 1, 6);
    for (int i = 0; i < 30 && !(m_per == 6 && m_pos == 2); i++) step(0, 1, 0, 0);
    step(0, 1, 1, 3);
    run(12);

    // Load 0 maps to 1.
    step(0, 1, 1, 0);
    run(4);

    // Freeze mid-period at ratio 4.
    step(0, 1, 1, 4);
    for (int i = 0; i < 20 && !(m_per == 4 && m_pos == 1); i++) step(0, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, $urandom_range(0, 63));
    run(9);

    // Reset at cnt=3 of ratio 8 with a pending ratio.
    step(0, 1, 1, 8);
    for (int i = 0; i < 30 && !(m_per == 8 && m_pos == 2); i++) step(0, 1, 0, 0);
    step(0, 1, 1, 5);
    step(1, 1, 0, 0);
    run(10);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 99) < 12),
           ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(0, 12));
    end

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk_in);
    repeat (2) @(posedge clk_in);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
